// File: rtl/ift_sram_arbiter.sv
// rtl/ift_sram_arbiter.sv - two-requester round-robin arbiter for one single-port IFT SRAM
//
// Purpose:
//   Shares one single-port SRAM between two requesters (e.g. instruction fetch
//   and data port). At most one request is accepted per cycle. Read data coming
//   back one cycle later is steered to the requester that issued the read.
//   Conservative taint tracking: any tainted input to the arbitration decision
//   taints the grant, the SRAM address/control/data and the returned data.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   valid_i/write_i [2]                per-requester request valid / write flag
//   addr_i  [2][Aw]                    per-requester word address
//   wdata_i/wmask_i [2][Width]         per-requester write data / bit write mask
//   ready_o [2]                        one-hot grant
//   rvalid_o [2], rdata_o [2][Width]   read response, one cycle after the grant
//   sram_req_o, sram_write_o           SRAM request / write enable
//   sram_addr_o [Aw]                   SRAM word address
//   sram_wdata_o/sram_wmask_o [Width]  SRAM write data / write mask
//   sram_rdata_i [Width]               SRAM read data, one cycle after a read
//   *_t0                               taint twin of every port above

module ift_sram_arbiter #(
    parameter int unsigned Width     = 32,
    parameter int unsigned Aw        = 15,
    parameter int unsigned NumTaints = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic [1:0]            valid_i,
    input  logic [1:0]            valid_i_t0,
    input  logic [1:0]            write_i,
    input  logic [1:0]            write_i_t0,
    input  logic [1:0][Aw-1:0]    addr_i,
    input  logic [1:0][Aw-1:0]    addr_i_t0,
    input  logic [1:0][Width-1:0] wdata_i,
    input  logic [1:0][Width-1:0] wdata_i_t0,
    input  logic [1:0][Width-1:0] wmask_i,
    input  logic [1:0][Width-1:0] wmask_i_t0,

    output logic [1:0]            ready_o,
    output logic [1:0]            ready_o_t0,
    output logic [1:0]            rvalid_o,
    output logic [1:0]            rvalid_o_t0,
    output logic [1:0][Width-1:0] rdata_o,
    output logic [1:0][Width-1:0] rdata_o_t0,

    output logic                  sram_req_o,
    output logic                  sram_req_o_t0,
    output logic                  sram_write_o,
    output logic                  sram_write_o_t0,
    output logic [Aw-1:0]         sram_addr_o,
    output logic [Aw-1:0]         sram_addr_o_t0,
    output logic [Width-1:0]      sram_wdata_o,
    output logic [Width-1:0]      sram_wdata_o_t0,
    output logic [Width-1:0]      sram_wmask_o,
    output logic [Width-1:0]      sram_wmask_o_t0,
    input  logic [Width-1:0]      sram_rdata_i,
    input  logic [Width-1:0]      sram_rdata_i_t0
);

    if (NumTaints != 1) begin : gen_num_taints_check
        $fatal(1, "ift_sram_arbiter: only NumTaints == 1 is supported");
    end

    // Round-robin pointer: index of the requester that wins the next contended cycle.
    logic prio_q, prio_d;
    logic prio_taint_q, prio_taint_d;

    // Outstanding read response: valid flag, owner and taint.
    logic rsp_valid_q, rsp_valid_d;
    logic rsp_id_q, rsp_id_d;
    logic rsp_taint_q, rsp_taint_d;

    logic contended;
    logic gnt_any;
    logic gnt_id;
    logic grant_taint;

    // Grant decision. With a single valid requester the pointer is irrelevant,
    // so the winner is requester 1 exactly when requester 0 is idle.
    always_comb begin
        contended   = valid_i[0] & valid_i[1];
        gnt_any     = |valid_i;
        gnt_id      = contended ? prio_q : ~valid_i[0];
        // The pointer only influences the outcome under contention, so its
        // taint only propagates then.
        grant_taint = (|valid_i_t0) | (prio_taint_q & contended);
    end

    always_comb begin
        prio_d       = prio_q;
        prio_taint_d = prio_taint_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_taint_d  = 1'b0;
        if (gnt_any) begin
            prio_d       = ~gnt_id;
            prio_taint_d = grant_taint;
            rsp_valid_d  = ~write_i[gnt_id];
            if (!write_i[gnt_id]) begin
                rsp_id_d = gnt_id;
            end
            // A tainted write flag makes it uncertain whether a response exists.
            rsp_taint_d  = grant_taint | write_i_t0[gnt_id];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q       <= 1'b0;
            prio_taint_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_taint_q  <= 1'b0;
        end else begin
            prio_q       <= prio_d;
            prio_taint_q <= prio_taint_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_taint_q  <= rsp_taint_d;
        end
    end

    // Output drive. Everything is forced to zero while reset is asserted, so
    // combinational paths from valid_i cannot leak a request during reset.
    always_comb begin
        ready_o         = '0;
        ready_o_t0      = '0;
        rvalid_o        = '0;
        rvalid_o_t0     = '0;
        rdata_o         = '0;
        rdata_o_t0      = '0;
        sram_req_o      = 1'b0;
        sram_req_o_t0   = 1'b0;
        sram_write_o    = 1'b0;
        sram_write_o_t0 = 1'b0;
        sram_addr_o     = '0;
        sram_addr_o_t0  = '0;
        sram_wdata_o    = '0;
        sram_wdata_o_t0 = '0;
        sram_wmask_o    = '0;
        sram_wmask_o_t0 = '0;

        if (rst_ni) begin
            sram_req_o    = gnt_any;
            sram_req_o_t0 = |valid_i_t0;
            ready_o_t0    = {2{grant_taint}};

            if (gnt_any) begin
                ready_o[gnt_id]  = 1'b1;
                sram_write_o     = write_i[gnt_id];
                sram_addr_o      = addr_i[gnt_id];
                sram_wdata_o     = wdata_i[gnt_id];
                sram_wmask_o     = wmask_i[gnt_id];
                sram_write_o_t0  = write_i_t0[gnt_id];
                sram_addr_o_t0   = addr_i_t0[gnt_id];
                sram_wdata_o_t0  = wdata_i_t0[gnt_id];
                sram_wmask_o_t0  = wmask_i_t0[gnt_id];
            end

            // A tainted grant means the whole SRAM access is attacker-influenced.
            sram_write_o_t0 = sram_write_o_t0 | grant_taint;
            sram_addr_o_t0  = sram_addr_o_t0  | {Aw{grant_taint}};
            sram_wdata_o_t0 = sram_wdata_o_t0 | {Width{grant_taint}};
            sram_wmask_o_t0 = sram_wmask_o_t0 | {Width{grant_taint}};

            rvalid_o[rsp_id_q] = rsp_valid_q;
            rvalid_o_t0        = {2{rsp_taint_q}};

            for (int i = 0; i < 2; i++) begin
                if (rvalid_o[i]) begin
                    rdata_o[i] = sram_rdata_i;
                end
                // With a tainted response either port may see data, so both
                // ports carry the taint even when their rvalid is low.
                if (rvalid_o[i] || rsp_taint_q) begin
                    rdata_o_t0[i] = sram_rdata_i_t0 | {Width{rsp_taint_q}};
                end
            end
        end
    end

endmodule

// File: tb/tb_ift_sram_arbiter.sv
// tb/tb_ift_sram_arbiter.sv - self-checking bench for ift_sram_arbiter

module tb_ift_sram_arbiter;

    localparam int W  = 32;
    localparam int AW = 15;

    logic clk = 1'b0;
    logic rst_ni;

    logic [1:0]          valid_i, valid_i_t0, write_i, write_i_t0;
    logic [1:0][AW-1:0]  addr_i, addr_i_t0;
    logic [1:0][W-1:0]   wdata_i, wdata_i_t0, wmask_i, wmask_i_t0;
    logic [1:0]          ready_o, ready_o_t0, rvalid_o, rvalid_o_t0;
    logic [1:0][W-1:0]   rdata_o, rdata_o_t0;
    logic                sram_req_o, sram_req_o_t0, sram_write_o, sram_write_o_t0;
    logic [AW-1:0]       sram_addr_o, sram_addr_o_t0;
    logic [W-1:0]        sram_wdata_o, sram_wdata_o_t0, sram_wmask_o, sram_wmask_o_t0;
    logic [W-1:0]        sram_rdata_i = '0;
    logic [W-1:0]        sram_rdata_i_t0;

    int n_checks = 0;
    int n_errors = 0;

    // SRAM stub memory and the reference model's own copy of the contents.
    logic [W-1:0] stub_mem [64];
    logic [W-1:0] ref_mem  [64];

    // Reference model state: who wins the next tie, its taint, pending response.
    int           m_prio = 0;
    bit           m_ptaint = 0;
    bit           m_rv = 0;
    int           m_rid = 0;
    bit           m_rt = 0;
    logic [W-1:0] m_rdat = '0;

    // Per-cycle decision computed by the model in check_cycle, consumed by advance.
    bit c_any;
    int c_win;
    bit c_gt;

    always #5 clk = ~clk;

    ift_sram_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .valid_i(valid_i), .valid_i_t0(valid_i_t0),
        .write_i(write_i), .write_i_t0(write_i_t0),
        .addr_i(addr_i), .addr_i_t0(addr_i_t0),
        .wdata_i(wdata_i), .wdata_i_t0(wdata_i_t0),
        .wmask_i(wmask_i), .wmask_i_t0(wmask_i_t0),
        .ready_o(ready_o), .ready_o_t0(ready_o_t0),
        .rvalid_o(rvalid_o), .rvalid_o_t0(rvalid_o_t0),
        .rdata_o(rdata_o), .rdata_o_t0(rdata_o_t0),
        .sram_req_o(sram_req_o), .sram_req_o_t0(sram_req_o_t0),
        .sram_write_o(sram_write_o), .sram_write_o_t0(sram_write_o_t0),
        .sram_addr_o(sram_addr_o), .sram_addr_o_t0(sram_addr_o_t0),
        .sram_wdata_o(sram_wdata_o), .sram_wdata_o_t0(sram_wdata_o_t0),
        .sram_wmask_o(sram_wmask_o), .sram_wmask_o_t0(sram_wmask_o_t0),
        .sram_rdata_i(sram_rdata_i), .sram_rdata_i_t0(sram_rdata_i_t0)
    );

    // Single-port SRAM stub with one-cycle read latency.
    always @(posedge clk) begin
        if (sram_req_o) begin
            if (sram_write_o) begin
                stub_mem[sram_addr_o[5:0]] <= (stub_mem[sram_addr_o[5:0]] & ~sram_wmask_o)
                                            | (sram_wdata_o & sram_wmask_o);
            end else begin
                sram_rdata_i <= stub_mem[sram_addr_o[5:0]];
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        valid_i = '0; valid_i_t0 = '0; write_i = '0; write_i_t0 = '0;
        addr_i = '0; addr_i_t0 = '0; wdata_i = '0; wdata_i_t0 = '0;
        wmask_i = '0; wmask_i_t0 = '0; sram_rdata_i_t0 = '0;
    endtask

    task automatic model_reset();
        m_prio = 0; m_ptaint = 0; m_rv = 0; m_rid = 0; m_rt = 0;
    endtask

    // Called right after inputs change (at the falling edge): compares every
    // output with what the arbitration rules predict for this cycle.
    task automatic check_cycle();
        bit                contended;
        logic [1:0]        e_rdy, e_rv;
        logic [1:0][W-1:0] e_rd, e_rdt;
        logic [AW-1:0]     e_at;
        logic [W-1:0]      e_wdt, e_wmt;
        #1;
        contended = valid_i[0] && valid_i[1];
        c_any     = (valid_i != 2'b00);
        c_win     = contended ? m_prio : (valid_i[0] ? 0 : 1);
        c_gt      = (valid_i_t0 != 2'b00) || (m_ptaint && contended);

        e_rdy = c_any ? ((c_win == 1) ? 2'b10 : 2'b01) : 2'b00;
        e_rv  = m_rv ? ((m_rid == 1) ? 2'b10 : 2'b01) : 2'b00;
        for (int i = 0; i < 2; i++) begin
            e_rd[i]  = e_rv[i] ? m_rdat : '0;
            e_rdt[i] = (e_rv[i] || m_rt) ? (sram_rdata_i_t0 | (m_rt ? {W{1'b1}} : '0)) : '0;
        end
        e_at  = c_gt ? {AW{1'b1}} : (c_any ? addr_i_t0[c_win]  : '0);
        e_wdt = c_gt ? {W{1'b1}}  : (c_any ? wdata_i_t0[c_win] : '0);
        e_wmt = c_gt ? {W{1'b1}}  : (c_any ? wmask_i_t0[c_win] : '0);

        check_val("ready",        ready_o, e_rdy);
        check_val("ready_t0",     ready_o_t0, c_gt ? 2'b11 : 2'b00);
        check_val("rvalid",       rvalid_o, e_rv);
        check_val("rvalid_t0",    rvalid_o_t0, m_rt ? 2'b11 : 2'b00);
        check_val("rdata",        rdata_o, e_rd);
        check_val("rdata_t0",     rdata_o_t0, e_rdt);
        check_val("sram_req",     sram_req_o, c_any);
        check_val("sram_req_t0",  sram_req_o_t0, valid_i_t0 != 2'b00);
        check_val("sram_write",   sram_write_o, c_any ? write_i[c_win] : 1'b0);
        check_val("sram_write_t0", sram_write_o_t0, c_gt || (c_any && write_i_t0[c_win]));
        check_val("sram_addr",    sram_addr_o, c_any ? addr_i[c_win] : '0);
        check_val("sram_addr_t0", sram_addr_o_t0, e_at);
        check_val("sram_wdata",   sram_wdata_o, c_any ? wdata_i[c_win] : '0);
        check_val("sram_wdata_t0", sram_wdata_o_t0, e_wdt);
        check_val("sram_wmask",   sram_wmask_o, c_any ? wmask_i[c_win] : '0);
        check_val("sram_wmask_t0", sram_wmask_o_t0, e_wmt);
    endtask

    // Clock edge: the model commits the accepted request, then waits for the
    // next falling edge where new inputs are applied.
    task automatic advance();
        logic [5:0] a;
        @(posedge clk);
        if (c_any) begin
            a = addr_i[c_win][5:0];
            if (write_i[c_win]) begin
                ref_mem[a] = (ref_mem[a] & ~wmask_i[c_win]) | (wdata_i[c_win] & wmask_i[c_win]);
                m_rv = 0;
            end else begin
                m_rdat = ref_mem[a];
                m_rv   = 1;
                m_rid  = c_win;
            end
            m_rt     = c_gt || write_i_t0[c_win];
            m_prio   = (c_win == 0) ? 1 : 0;
            m_ptaint = c_gt;
        end else begin
            m_rv = 0;
            m_rt = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            stub_mem[i] = $urandom;
            ref_mem[i]  = stub_mem[i];
        end
        stub_mem[16] = 32'hDEADBEEF;
        ref_mem[16]  = 32'hDEADBEEF;

        rst_ni = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);

        // Outputs stay quiet during reset even with requests present.
        valid_i = 2'b11; valid_i_t0 = 2'b01;
        #1;
        check_val("rst_ready",      ready_o, 2'b00);
        check_val("rst_ready_t0",   ready_o_t0, 2'b00);
        check_val("rst_sram_req",   sram_req_o, 1'b0);
        check_val("rst_sram_req_t0", sram_req_o_t0, 1'b0);
        check_val("rst_rvalid",     rvalid_o, 2'b00);
        clear_inputs();
        @(negedge clk);
        rst_ni = 1'b1;

        // Requester 1 alone reads 0x10.
        valid_i = 2'b10; addr_i[1] = 15'h10;
        check_cycle();
        check_val("t1_ready", ready_o, 2'b10);
        advance();
        clear_inputs();
        check_cycle();
        check_val("t1_rvalid", rvalid_o, 2'b10);
        check_val("t1_rdata1", rdata_o[1], 32'hDEADBEEF);
        advance();

        // Constant contention: grants alternate 0,1,0,1 with responses one cycle behind.
        for (int k = 0; k < 5; k++) begin
            valid_i = (k < 4) ? 2'b11 : 2'b00;
            addr_i[0] = 15'(k); addr_i[1] = 15'(k + 8);
            check_cycle();
            if (k < 4) check_val("t2_ready", ready_o, (k % 2 == 1) ? 2'b10 : 2'b01);
            if (k > 0) check_val("t2_rvalid", rvalid_o, ((k - 1) % 2 == 1) ? 2'b10 : 2'b01);
            advance();
        end
        clear_inputs();

        // Requester 0 write with a half-word mask.
        valid_i = 2'b01; write_i = 2'b01; addr_i[0] = 15'h3;
        wdata_i[0] = 32'h12345678; wmask_i[0] = 32'h0000FFFF;
        check_cycle();
        check_val("t3_write", sram_write_o, 1'b1);
        check_val("t3_wmask", sram_wmask_o, 32'h0000FFFF);
        advance();
        clear_inputs();
        check_cycle();
        check_val("t3_no_rvalid", rvalid_o, 2'b00);
        advance();

        // Tainted valid under contention, then taint persistence and clearing.
        valid_i = 2'b11; valid_i_t0 = 2'b10;
        check_cycle();
        check_val("t4_ready_t0", ready_o_t0, 2'b11);
        check_val("t4_addr_t0", sram_addr_o_t0, 15'h7FFF);
        advance();
        clear_inputs();
        check_cycle();
        check_val("t4_rdata_t0", rdata_o_t0, 64'hFFFF_FFFF_FFFF_FFFF);
        advance();
        valid_i = 2'b11;
        check_cycle();
        check_val("t4_sticky_t0", ready_o_t0, 2'b11);
        advance();
        valid_i = 2'b01;
        check_cycle();
        check_val("t4_clean_t0", ready_o_t0, 2'b00);
        advance();
        valid_i = 2'b11;
        check_cycle();
        check_val("t4_cleared_t0", ready_o_t0, 2'b00);
        advance();
        clear_inputs();
        check_cycle();
        advance();

        // Clean read: data taint passes through only to the owning requester.
        valid_i = 2'b01; addr_i[0] = 15'h5;
        check_cycle();
        advance();
        clear_inputs();
        sram_rdata_i_t0 = 32'h000000F0;
        check_cycle();
        check_val("t5_rdata_t0", rdata_o_t0, 64'h0000_0000_0000_00F0);
        advance();
        clear_inputs();

        // Reset with a response in flight and the pointer pointing at requester 1.
        valid_i = 2'b01; addr_i[0] = 15'h7;
        check_cycle();
        advance();
        clear_inputs();
        check_cycle();
        check_val("t6_rvalid_pre", rvalid_o, 2'b01);
        rst_ni = 1'b0;
        #1;
        check_val("t6_rvalid_rst", rvalid_o, 2'b00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        valid_i = 2'b11;
        check_cycle();
        check_val("t6_ready_after", ready_o, 2'b01);
        advance();
        clear_inputs();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            valid_i = 2'($urandom_range(0, 3));
            write_i = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                addr_i[i]     = 15'($urandom_range(0, 63));
                wdata_i[i]    = $urandom;
                wmask_i[i]    = $urandom;
                valid_i_t0[i] = ($urandom_range(0, 9) == 0);
                write_i_t0[i] = ($urandom_range(0, 9) == 0);
                addr_i_t0[i]  = ($urandom_range(0, 7) == 0) ? 15'($urandom) : '0;
                wdata_i_t0[i] = ($urandom_range(0, 7) == 0) ? $urandom : '0;
                wmask_i_t0[i] = ($urandom_range(0, 7) == 0) ? $urandom : '0;
            end
            sram_rdata_i_t0 = ($urandom_range(0, 3) == 0) ? $urandom : '0;
            check_cycle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
